// File: rtl/attn_stream_pkg.sv
// attn_stream_pkg: shared state encoding and frame-slicing helpers for the attention stream blocks
package attn_stream_pkg;
  typedef enum logic {ST_IDLE, ST_STREAM} state_t;
  function automatic int idx_width(input int count);
    return count > 1 ? $clog2(count) : 1;
  endfunction
  function automatic int elem_lo(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/attention_output_streamer.sv
// attention_output_streamer: captures a packed (L, N, E) frame on load and streams it one element per valid/ready beat
module attention_output_streamer
  import attn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L = 8,
  parameter int N = 1,
  parameter int E = 8,
  localparam int COUNT = L * N * E,
  localparam int IDX_W = idx_width(COUNT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [DATA_WIDTH*COUNT-1:0] data_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [IDX_W-1:0]            m_index,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);
  state_t state, state_n;
  logic [DATA_WIDTH*COUNT-1:0] frame_q;
  logic [DATA_WIDTH-1:0] data_n;
  logic [IDX_W-1:0] idx, idx_n, nxt;
  logic capture, last_n, done_n, overrun_n;
  assign m_valid = state == ST_STREAM;
  assign busy    = state == ST_STREAM;
  assign m_index = idx;
  // m_data/m_last are precomputed for the next beat so no path runs from m_ready to the outputs
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    data_n    = m_data;
    last_n    = m_last;
    done_n    = 1'b0;
    capture   = 1'b0;
    overrun_n = load && state == ST_STREAM;
    nxt       = idx + 1'b1;
    if (state == ST_IDLE) begin
      if (load) begin
        capture = 1'b1;
        state_n = ST_STREAM;
        idx_n   = '0;
        data_n  = data_in[elem_lo(0, DATA_WIDTH) +: DATA_WIDTH];
        last_n  = LAST == '0;
      end
    end else if (m_ready) begin
      if (idx == LAST) begin
        state_n = ST_IDLE;
        idx_n   = '0;
        last_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        idx_n  = nxt;
        data_n = frame_q[elem_lo(int'(nxt), DATA_WIDTH) +: DATA_WIDTH];
        last_n = nxt == LAST;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frame_q <= '0;
      idx     <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      m_data  <= data_n;
      m_last  <= last_n;
      done    <= done_n;
      overrun <= overrun_n;
      if (capture) frame_q <= data_in;
    end
  end
endmodule

// File: tb/tb_attention_output_streamer.sv
// tb_attention_output_streamer: directed and randomized frames checked against a frame/position reference model
module tb_attention_output_streamer;
  localparam int DW = 16;
  localparam int COUNT = 64;
  localparam int IW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic m_ready = 1'b0;
  logic [DW*COUNT-1:0] data_in;
  logic m_valid, m_last, busy, done, overrun;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_index;
  logic [DW-1:0] in_el [COUNT];
  logic [DW-1:0] mdl_frame [COUNT];
  bit mdl_act, mdl_done, mdl_ovr;
  int mdl_pos;
  int tests = 0;
  int fails = 0;
  int n_done = 0;

  attention_output_streamer #(.DATA_WIDTH(DW), .L(8), .N(1), .E(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < COUNT; k++) data_in[k*DW +: DW] = in_el[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode, input logic [DW-1:0] base);
    for (int k = 0; k < COUNT; k++)
      in_el[k] = mode == 0 ? base + DW'(k) : mode == 1 ? 16'hFFFF : DW'($urandom);
  endtask

  task automatic check_outputs();
    chk("m_valid", 32'(m_valid), 32'(mdl_act));
    chk("busy", 32'(busy), 32'(mdl_act));
    chk("done", 32'(done), 32'(mdl_done));
    chk("overrun", 32'(overrun), 32'(mdl_ovr));
    if (mdl_act) begin
      chk("m_data", 32'(m_data), 32'(mdl_frame[mdl_pos]));
      chk("m_index", 32'(m_index), 32'(mdl_pos));
      chk("m_last", 32'(m_last), 32'(mdl_pos == COUNT - 1));
    end
  endtask

  // One clock: inputs applied now, model advanced on the edge, outputs checked 1ns later
  task automatic cyc(input bit ld, input bit rdy);
    bit act_was;
    load = ld;
    m_ready = rdy;
    @(posedge clk);
    act_was = mdl_act;
    mdl_done = act_was && rdy && mdl_pos == COUNT - 1;
    mdl_ovr = act_was && ld;
    if (act_was) begin
      if (rdy) begin
        if (mdl_pos == COUNT - 1) begin
          mdl_act = 1'b0;
          mdl_pos = 0;
        end else mdl_pos++;
      end
    end else if (ld) begin
      for (int k = 0; k < COUNT; k++) mdl_frame[k] = in_el[k];
      mdl_act = 1'b1;
      mdl_pos = 0;
    end
    if (mdl_done) n_done++;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_index", 32'(m_index), 0);
  endtask

  initial begin
    int d0;
    mdl_act = 1'b0; mdl_pos = 0; mdl_done = 1'b0; mdl_ovr = 1'b0;
    fill(0, 16'h0100);
    #12;
    check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 1);
    // Ready held high: 64 zero-bubble beats, done the cycle after the last
    fill(0, 16'h0100);
    cyc(1, 1);
    for (int i = 0; i < COUNT; i++) cyc(0, 1);
    chk("frameA_done_seen", 32'(done), 1);
    cyc(0, 1);
    // Backpressure pattern 1,0,0,1
    d0 = n_done;
    cyc(1, 0);
    for (int i = 0; i < 4 * COUNT; i++) cyc(0, (i % 4) == 0 || (i % 4) == 3);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    chk("bp_done_count", 32'(n_done - d0), 1);
    // Load of all-FFFF during beat 10 is rejected
    fill(0, 16'h0100);
    cyc(1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1);
    fill(1, 16'h0000);
    cyc(1, 1);
    for (int i = 0; i < COUNT; i++) cyc(0, 1);
    chk("ovr_no_second_frame", 32'(m_valid), 0);
    // Load in the done cycle starts the next frame immediately
    fill(0, 16'h0100);
    cyc(1, 1);
    for (int i = 0; i < COUNT; i++) cyc(0, 1);
    fill(0, 16'h0200);
    cyc(1, 1);
    chk("b2b_first", 32'(m_data), 32'h0200);
    for (int i = 0; i < COUNT; i++) cyc(0, 1);
    cyc(0, 1);
    // Asynchronous reset at beat 20
    d0 = n_done;
    fill(0, 16'h0100);
    cyc(1, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1);
    rst_n = 1'b0;
    #1;
    mdl_act = 1'b0; mdl_pos = 0; mdl_done = 1'b0; mdl_ovr = 1'b0;
    check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1);
    chk("rst_no_done", 32'(n_done - d0), 0);
    fill(2, 16'h0000);
    cyc(1, 1);
    chk("rst_restart_index", 32'(m_index), 0);
    for (int i = 0; i < COUNT; i++) cyc(0, 1);
    // Ready low for five cycles after load
    fill(0, 16'h0100);
    cyc(1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0);
    chk("stall_hold", 32'(m_data), 32'h0100);
    for (int i = 0; i < COUNT + 2; i++) cyc(0, 1);
    // Random data, ready and loads
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) fill(2, 16'h0000);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4 * COUNT; i++) cyc(0, 1);
    chk("final_idle", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/attention_output_streamer.md
Name: attention_output_streamer

Overview:
Transmit-side companion to the self-attention top level. It captures the packed (L, N, E) attention result when the top level pulses out_valid. It then streams the result one DATA_WIDTH element per beat over a valid/ready interface to downstream logic (DMA, host FIFO, next layer). It reports completion with a start/done-style pulse, matching the codebase's block handshake.

Parameters:
DATA_WIDTH, 16, bits per element
L, 8, sequence length
N, 1, batch size
E, 8, embedding size
COUNT (localparam), L*N*E, elements per frame
IDX_W (localparam), max(1, $clog2(COUNT)), index width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load  input  1  single-cycle capture strobe (driven by the top level's out_valid)
data_in  input  DATA_WIDTH*COUNT  packed frame; element k = data_in[k*DATA_WIDTH +: DATA_WIDTH]
m_valid  output  1  stream beat valid
m_ready  input  1  downstream ready
m_data  output  DATA_WIDTH  current element
m_index  output  IDX_W  index k of the current element
m_last  output  1  high with element COUNT-1
busy  output  1  frame held or streaming
done  output  1  one-cycle pulse after the final beat is accepted
overrun  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: state IDLE, frame buffer 0, idx 0; m_valid, m_last, busy, done, overrun all 0; m_data 0; m_index 0.
- State IDLE:
  - load=1: buffer <= data_in, idx <= 0, state <= STREAM.
  - Next cycle: m_valid=1, busy=1, m_data=element 0.
  - Latency from load to first valid beat: 1 cycle.
- State STREAM:
  - m_valid=1 continuously.
  - m_data = buffer element idx; m_index = idx; m_last = (idx == COUNT-1).
- Handshake (beat transfers when m_valid && m_ready):
  - m_valid never deasserts without a transfer.
  - m_data, m_index and m_last stay stable while m_valid && !m_ready.
  - Transfer with idx < COUNT-1: idx <= idx+1. Zero-bubble: one beat per cycle when m_ready is held high.
  - Transfer with idx == COUNT-1: state <= IDLE, done <= 1 for exactly one cycle, m_valid/busy <= 0, idx <= 0.
- Frame duration: exactly COUNT beats; done is asserted the cycle after the final transfer.
- load while in STREAM (including the same cycle as the final transfer):
  - Load is ignored; buffer and idx are untouched.
  - overrun pulses high the next cycle for one cycle.
- load in the cycle done is high: state is IDLE, so the load is accepted normally (back-to-back frames, one idle cycle between them).
- m_ready is don't-care in IDLE.
- m_data outside STREAM holds the last driven value. It has no meaning while m_valid=0.
- Asynchronous reset mid-frame: immediate return to reset values. The partial frame is discarded, no done pulse is issued, and the next load restarts at element 0.
- COUNT=1 is legal: a single beat with m_last=1.
- All outputs are registered. There are no combinational paths from m_ready to m_valid, m_data or m_last.

Decomposition:
- Shared package attn_stream_pkg holds:
  - state enum {ST_IDLE, ST_STREAM}
  - function idx_width(count)
  - element-slice helper (k, DATA_WIDTH)
- attention_input_loader (the future receive-side deserializer for x_in) reuses the same package.
- Single module; no sub-module needed. The frame buffer is a flat register with an indexed part-select mux.

Test Plan:
- Ready held high, element k = 16'h0100+k, load at cycle t:
  - 64 beats on cycles t+1..t+64, m_data 0100..013F, m_index 0..63.
  - m_last only at index 63; done at t+65; busy low at t+65.
- Backpressure, m_ready pattern 1,0,0,1 repeated: every stall cycle holds m_data/m_index constant; all 64 elements delivered in order; done exactly once.
- load with data_in=all 16'hFFFF during beat 10 of a frame: overrun one-cycle pulse next cycle; remaining beats still 010A..013F; no second frame follows.
- load asserted in the done cycle with element k = 16'h0200+k: second frame starts the next cycle with 0200; no overrun.
- rst_n low at beat 20: all outputs 0 immediately; no done. New load then streams from element 0.
- m_ready low for the first 5 cycles after load: m_valid=1 with m_data=0100 held; the first transfer occurs on the first ready cycle.
